// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider: default width,
// FSM state encodings and the divide-by-zero quotient pattern.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] ITER_ENC = 2'd1;
   localparam logic [1:0] FIX_ENC  = 2'd2;
   localparam logic [1:0] DONE_ENC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE_ENC,
      ST_ITER = ITER_ENC,
      ST_FIX  = FIX_ENC,
      ST_DONE = DONE_ENC
   } div_state_t;

   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_sequencer_if.sv
// Start/busy/done handshake and operand/result bus between the control unit
// (master) and the divide sequencer (slave).
interface div_sequencer_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);

   logic               start;
   logic               is_signed;
   logic [WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]   divisor;
   logic               busy;
   logic               done;
   logic               div_by_zero;
   logic [2*WIDTH-1:0] result;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, div_by_zero, result
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, div_by_zero, result
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {A,Qr} left, trial
// subtract Mr, keep or restore depending on the sign bit of the trial.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] qr,
   input  logic [WIDTH-1:0] mr,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] qr_next
);

   logic [WIDTH:0] a_shift;
   logic [WIDTH:0] a_trial;
   logic           unused_a_msb;

   // The partial remainder is always below Mr on entry, so its top bit is
   // clear and shifting it out loses nothing.
   assign unused_a_msb = a[WIDTH];

   // NOTE: every output of a combinational block gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      a_shift = {a[WIDTH-1:0], qr[WIDTH-1]};
      a_trial = a_shift - {1'b0, mr};
      if (a_trial[WIDTH]) begin
         a_next  = a_shift;
         qr_next = {qr[WIDTH-2:0], 1'b0};
      end else begin
         a_next  = a_trial;
         qr_next = {qr[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned restoring divider: one step per clock, sign
// fix-up, divide-by-zero shortcut, result held as {remainder, quotient}.
module div_sequencer
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic            clock,
   input  logic            clear,
   div_sequencer_if.slave  bus
);

   localparam int               CNT_W     = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO_QUO  = {WIDTH{DIV0_QUOTIENT[0]}};

   div_state_t         state, state_n;
   logic               busy, busy_n;
   logic               done, done_n;
   logic               div_by_zero;
   logic [2*WIDTH-1:0] result;

   logic [WIDTH:0]     a, a_next;
   logic [WIDTH-1:0]   qr, qr_next;
   logic [WIDTH-1:0]   mr;
   logic [CNT_W-1:0]   cnt;
   logic               neg_quo;
   logic               neg_rem;

   logic               div_zero;
   logic [WIDTH-1:0]   dividend_mag;
   logic [WIDTH-1:0]   divisor_mag;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign div_zero     = (bus.divisor == '0);
   assign dividend_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
   assign divisor_mag  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
   assign quo_fix      = neg_quo ? -qr : qr;
   assign rem_fix      = neg_rem ? -a[WIDTH-1:0] : a[WIDTH-1:0];

   div_step #(.WIDTH(WIDTH)) u_step (
      .a       (a),
      .qr      (qr),
      .mr      (mr),
      .a_next  (a_next),
      .qr_next (qr_next)
   );

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_n = div_zero ? ST_DONE : ST_ITER;
               done_n  = div_zero;
            end
         end
         ST_ITER: begin
            busy_n = 1'b1;
            if (cnt == LAST_STEP) state_n = ST_FIX;
         end
         ST_FIX: begin
            busy_n  = 1'b1;
            done_n  = 1'b1;
            state_n = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Operands are captured only on acceptance; result changes only at completion.
   always_ff @(posedge clock) begin
      if (clear) begin
         a           <= '0;
         qr          <= '0;
         mr          <= '0;
         cnt         <= '0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         div_by_zero <= 1'b0;
         result      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start && div_zero) begin
                  result      <= {bus.dividend, ZERO_QUO};
                  div_by_zero <= 1'b1;
               end else if (bus.start) begin
                  a       <= '0;
                  qr      <= dividend_mag;
                  mr      <= divisor_mag;
                  cnt     <= '0;
                  neg_rem <= bus.is_signed & bus.dividend[WIDTH-1];
                  neg_quo <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
               end
            end
            ST_ITER: begin
               a   <= a_next;
               qr  <= qr_next;
               cnt <= cnt + CNT_W'(1);
            end
            ST_FIX: begin
               result      <= {rem_fix, quo_fix};
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.div_by_zero = div_by_zero;
   assign bus.result      = result;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_div_sequencer;

   localparam int W = 32;

   logic clock = 1'b0;
   logic clear;
   int   total = 0;
   int   bad   = 0;

   div_sequencer_if #(.WIDTH(W)) bus ();

   div_sequencer #(.WIDTH(W)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: truncating division on sign-extended 64-bit integers.
   function automatic logic [63:0] ref_div(input logic [31:0] dd, input logic [31:0] dv, input bit sg);
      longint          q, r;
      longint unsigned uq, ur;
      logic [31:0]     q32, r32;
      if (dv == 32'd0) return {dd, 32'hFFFF_FFFF};
      if (sg) begin
         q   = longint'(signed'(dd)) / longint'(signed'(dv));
         r   = longint'(signed'(dd)) % longint'(signed'(dv));
         q32 = q[31:0];
         r32 = r[31:0];
      end else begin
         uq  = {32'd0, dd} / {32'd0, dv};
         ur  = {32'd0, dd} % {32'd0, dv};
         q32 = uq[31:0];
         r32 = ur[31:0];
      end
      return {r32, q32};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one request, scramble operands while busy, then check timing and result.
   task automatic run_op(input logic [31:0] dd, input logic [31:0] dv, input bit sg, input string tag);
      logic [63:0] exp;
      int          lat;
      int          busy_cycles;
      exp = ref_div(dd, dv, sg);
      bus.start     = 1'b1;
      bus.dividend  = dd;
      bus.divisor   = dv;
      bus.is_signed = sg;
      tick();
      bus.start     = 1'b0;
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = 1'($urandom);
      lat = 0;
      busy_cycles = 0;
      while (!bus.done && lat < 100) begin
         if (bus.busy) busy_cycles++;
         tick();
         lat++;
      end
      if (bus.busy) busy_cycles++;
      check({tag, " latency"}, 64'(lat), (dv == 32'd0) ? 64'd0 : 64'd33);
      check({tag, " result"}, bus.result, exp);
      check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(dv == 32'd0));
      tick();
      check({tag, " done pulse"}, 64'(bus.done), 64'd0);
      check({tag, " busy cycles"}, 64'(busy_cycles), (dv == 32'd0) ? 64'd0 : 64'd33);
      check({tag, " held"}, bus.result, exp);
   endtask

   initial begin
      logic [31:0] dd, dv;
      logic [63:0] exp_a, exp_b;
      bit          sg;
      int          lat, pulses;

      // Reset wins over a concurrent divide-by-zero request.
      clear         = 1'b1;
      bus.start     = 1'b1;
      bus.dividend  = 32'd5;
      bus.divisor   = 32'd0;
      bus.is_signed = 1'b0;
      repeat (3) tick();
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset dbz", 64'(bus.div_by_zero), 64'd0);
      check("reset result", bus.result, 64'd0);
      bus.start = 1'b0;
      clear     = 1'b0;
      tick();
      check("idle after reset", 64'({bus.busy, bus.done}), 64'd0);

      run_op(32'd100, 32'd7, 1'b0, "u100/7");
      check("u100/7 literal", bus.result, 64'h00000002_0000000E);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7/2");
      check("s-7/2 literal", bus.result, 64'hFFFFFFFF_FFFFFFFD);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s7/-2");
      check("s7/-2 literal", bus.result, 64'h00000001_FFFFFFFD);
      run_op(32'd5, 32'd0, 1'b0, "div0");
      check("div0 literal", bus.result, 64'h00000005_FFFFFFFF);
      run_op(32'd100, 32'd7, 1'b0, "after div0");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "overflow");
      check("overflow literal", bus.result, 64'h00000000_80000000);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "uFFFFFFFF/1");
      run_op(32'hFFFF_FFFF, 32'd0, 1'b1, "s div0");

      // Abort mid-operation: no result, no done.
      bus.start     = 1'b1;
      bus.dividend  = 32'd1000;
      bus.divisor   = 32'd9;
      bus.is_signed = 1'b0;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort result", bus.result, 64'd0);
      check("abort dbz", 64'(bus.div_by_zero), 64'd0);
      pulses = 0;
      repeat (50) begin
         tick();
         if (bus.done || bus.busy) pulses++;
      end
      check("abort quiet", 64'(pulses), 64'd0);
      run_op(32'd20, 32'd3, 1'b0, "u20/3");
      check("u20/3 literal", bus.result, 64'h00000002_00000006);

      // Start toggled with changing operands while busy: only the first runs.
      dd = $urandom;
      dv = $urandom | 32'd1;
      exp_a = ref_div(dd, dv, 1'b1);
      bus.start     = 1'b1;
      bus.dividend  = dd;
      bus.divisor   = dv;
      bus.is_signed = 1'b1;
      tick();
      lat = 0;
      while (!bus.done && lat < 100) begin
         bus.start    = ~bus.start;
         bus.dividend = $urandom;
         bus.divisor  = $urandom;
         tick();
         lat++;
      end
      bus.start = 1'b0;
      check("storm latency", 64'(lat), 64'd33);
      check("storm result", bus.result, exp_a);
      pulses = 0;
      repeat (40) begin
         tick();
         if (bus.done) pulses++;
      end
      check("storm extra done", 64'(pulses), 64'd0);

      // Start held high: the second op is accepted the cycle after DONE.
      dd = $urandom;
      dv = $urandom_range(1, 1000);
      exp_a = ref_div(dd, dv, 1'b0);
      bus.start     = 1'b1;
      bus.dividend  = dd;
      bus.divisor   = dv;
      bus.is_signed = 1'b0;
      lat = 0;
      while (!bus.done && lat < 100) begin
         tick();
         lat++;
      end
      check("held first result", bus.result, exp_a);
      dd = $urandom;
      dv = $urandom | 32'h0000_0100;
      exp_b = ref_div(dd, dv, 1'b1);
      bus.dividend  = dd;
      bus.divisor   = dv;
      bus.is_signed = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.done && lat < 100);
      bus.start = 1'b0;
      check("held gap", 64'(lat), 64'd35);
      check("held second result", bus.result, exp_b);
      tick();

      // Random operands, with zero, small and negative-small divisors mixed in.
      for (int i = 0; i < 40; i++) begin
         sg = 1'($urandom);
         dd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
         case ($urandom_range(0, 7))
            0:       dv = 32'd0;
            1:       dv = 32'($urandom_range(1, 15));
            2:       dv = -32'($urandom_range(1, 15));
            default: dv = $urandom;
         endcase
         run_op(dd, dv, sg, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
